// File: rtl/p20_game_ctrl.sv
// p20_game_ctrl: top-level sequencer for the dino game.
//   Owns the OVER -> COUNT -> RUN state machine and the restart re-arm timer.
//   Drives game_rst and game_halt to the datapath blocks. Latches a per-slot cactus type
//   from the rng on each rising edge of cactus_select.
// Configuration macro: P20_GODMODE_EN. When defined, debug_in masks collision.
// Ports:
//   clk, sys_rst            clock, asynchronous active-high reset
//   jump_in, halt_in        player jump button, external pause
//   debug_in                collision mask (godmode builds only)
//   collision               dino/cactus overlap from rendering
//   cactus_select[2:0]      per-slot cactus active flags
//   random[4:0]             rng output; bits [4:2] feed slots [2:0]
//   game_rst                one-cycle restart pulse
//   game_halt               freeze datapath blocks
//   game_over               high in OVER
//   start_blink             blink enable to rendering
//   cactus_type[2:0]        latched cactus variant per slot
//   state[1:0]              debug view: OVER=0, COUNT=1, RUN=2
module p20_game_ctrl #(
  parameter int unsigned START_TIME = 30000000,
  parameter int unsigned REARM_TIME = 100000,
  parameter int unsigned BLINK_BIT  = 22,
  parameter int unsigned CTR_W      = 32
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       jump_in,
  input  logic       halt_in,
  input  logic       debug_in,
  input  logic       collision,
  input  logic [2:0] cactus_select,
  input  logic [4:0] random,
  output logic       game_rst,
  output logic       game_halt,
  output logic       game_over,
  output logic       start_blink,
  output logic [2:0] cactus_type,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StOver    = 2'd0,
    StCount   = 2'd1,
    StRun     = 2'd2,
    StIllegal = 2'd3
  } state_e;

  localparam logic [CTR_W-1:0] StartLast  = CTR_W'(START_TIME - 1);
  localparam logic [CTR_W-1:0] RearmLimit = CTR_W'(REARM_TIME);
  localparam logic [CTR_W-1:0] RearmSat   = CTR_W'(REARM_TIME + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CTR_W-1:0] r_start_ctr;
  logic [CTR_W-1:0] w_start_ctr_nxt;
  logic [CTR_W-1:0] r_rearm_ctr;
  logic             r_game_rst;
  logic             w_game_rst_nxt;
  logic [2:0]       r_cactus_type;
  logic [2:0]       r_select_last;
  logic [2:0]       w_select_rise;
  logic             w_collision;
  logic             w_unused_inputs;

`ifdef P20_GODMODE_EN
  assign w_collision     = collision & ~debug_in;
  assign w_unused_inputs = ^random[1:0];
`else
  assign w_collision     = collision;
  assign w_unused_inputs = ^{debug_in, random[1:0]};
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_start_ctr_nxt = r_start_ctr;
    w_game_rst_nxt  = 1'b0;
    unique case (r_state)
      StOver: begin
        if (jump_in && (r_rearm_ctr > RearmLimit)) begin
          w_state_nxt     = StCount;
          w_start_ctr_nxt = '0;
          w_game_rst_nxt  = 1'b1;
        end
      end
      StCount: begin
        // halt_in deliberately does not stall the start countdown
        w_start_ctr_nxt = r_start_ctr + 1'b1;
        if (r_start_ctr == StartLast) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        // Collision is honoured even while halted
        if (w_collision) begin
          w_state_nxt = StOver;
        end
      end
      default: w_state_nxt = StOver;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= StOver;
      r_start_ctr <= '0;
      r_game_rst  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_ctr <= w_start_ctr_nxt;
      r_game_rst  <= w_game_rst_nxt;
    end
  end

  // Re-arm timer: counts jump-free cycles, saturates so it never wraps back below the limit
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rearm_ctr <= '0;
    end else if (jump_in) begin
      r_rearm_ctr <= '0;
    end else if (r_rearm_ctr < RearmSat) begin
      r_rearm_ctr <= r_rearm_ctr + 1'b1;
    end
  end

  // Cactus type capture on rising select edges; independent of game state
  assign w_select_rise = cactus_select & ~r_select_last;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_select_last <= '0;
      r_cactus_type <= '0;
    end else begin
      r_select_last <= cactus_select;
      r_cactus_type <= (r_cactus_type & ~w_select_rise) | (random[4:2] & w_select_rise);
    end
  end

  assign game_rst    = r_game_rst;
  assign game_over   = (r_state == StOver);
  assign game_halt   = (r_state != StRun) | halt_in;
  assign start_blink = (r_state != StCount) | r_start_ctr[BLINK_BIT];
  assign cactus_type = r_cactus_type;
  assign state       = r_state;

endmodule

// File: tb/tb_p20_game_ctrl.sv
// Directed bench for p20_game_ctrl with shortened timing (START_TIME=64, REARM_TIME=20,
// BLINK_BIT=3). Expected values are hand-derived from the cycle timeline.
module tb_p20_game_ctrl;

  localparam int unsigned StartTime = 64;
  localparam int unsigned RearmTime = 20;

  logic       clk;
  logic       sys_rst;
  logic       jump_in;
  logic       halt_in;
  logic       debug_in;
  logic       collision;
  logic [2:0] cactus_select;
  logic [4:0] random;
  logic       game_rst;
  logic       game_halt;
  logic       game_over;
  logic       start_blink;
  logic [2:0] cactus_type;
  logic [1:0] state;

  int n_vec;
  int n_err;

  p20_game_ctrl #(
    .START_TIME(StartTime),
    .REARM_TIME(RearmTime),
    .BLINK_BIT (3),
    .CTR_W     (32)
  ) u_dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .jump_in      (jump_in),
    .halt_in      (halt_in),
    .debug_in     (debug_in),
    .collision    (collision),
    .cactus_select(cactus_select),
    .random       (random),
    .game_rst     (game_rst),
    .game_halt    (game_halt),
    .game_over    (game_over),
    .start_blink  (start_blink),
    .cactus_type  (cactus_type),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 1ns past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From OVER: wait out the re-arm window, jump, and run the full countdown into RUN
  task automatic start_game();
    jump_in = 1'b0;
    repeat (RearmTime + 1) tick();
    jump_in = 1'b1;
    tick();
    jump_in = 1'b0;
    check_eq("restart_rst", 32'(game_rst), 1);
    repeat (StartTime) tick();
    check_eq("restart_run", 32'(state), 2);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    sys_rst       = 1'b1;
    jump_in       = 1'b0;
    halt_in       = 1'b0;
    debug_in      = 1'b0;
    collision     = 1'b0;
    cactus_select = 3'b000;
    random        = 5'b00000;

    #3;
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_over", 32'(game_over), 1);
    check_eq("rst_grst", 32'(game_rst), 0);
    check_eq("rst_halt", 32'(game_halt), 1);
    check_eq("rst_blink", 32'(start_blink), 1);
    check_eq("rst_cactus", 32'(cactus_type), 0);

    tick();
    sys_rst = 1'b0;

    // Jump after only 10 quiet cycles: must not restart
    repeat (10) tick();
    jump_in = 1'b1;
    tick();
    jump_in = 1'b0;
    check_eq("early_grst", 32'(game_rst), 0);
    check_eq("early_state", 32'(state), 0);
    check_eq("early_over", 32'(game_over), 1);

    // Quiet REARM_TIME+1 cycles, then jump: restart pulse
    repeat (RearmTime + 1) tick();
    jump_in = 1'b1;
    tick();
    jump_in = 1'b0;
    check_eq("arm_grst", 32'(game_rst), 1);
    check_eq("arm_state", 32'(state), 1);
    check_eq("arm_over", 32'(game_over), 0);
    check_eq("arm_halt", 32'(game_halt), 1);
    check_eq("arm_blink", 32'(start_blink), 0);

    // Countdown: k cycles after the game_rst cycle, start_ctr == k; halt_in must not stall it
    for (int k = 1; k < int'(StartTime); k++) begin
      if (k == 20) halt_in = 1'b1;
      if (k == 30) halt_in = 1'b0;
      tick();
      if (k == 1) check_eq("pulse_width", 32'(game_rst), 0);
      check_eq("cnt_state", 32'(state), 1);
      check_eq("cnt_blink", 32'(start_blink), 32'((k >> 3) & 1));
    end
    tick();
    check_eq("run_state", 32'(state), 2);
    check_eq("run_halt", 32'(game_halt), 0);
    check_eq("run_blink", 32'(start_blink), 1);
    check_eq("run_grst", 32'(game_rst), 0);

    // Jump in RUN has no effect
    jump_in = 1'b1;
    tick();
    jump_in = 1'b0;
    check_eq("run_jump", 32'(state), 2);
    check_eq("run_jump_rst", 32'(game_rst), 0);

    // External halt forces game_halt combinationally
    halt_in = 1'b1;
    #1;
    check_eq("halt_in", 32'(game_halt), 1);

`ifdef P20_GODMODE_EN
    debug_in  = 1'b1;
    collision = 1'b1;
    tick();
    check_eq("god_state", 32'(state), 2);
    check_eq("god_over", 32'(game_over), 0);
    debug_in = 1'b0;
`endif

    // Collision while halted still ends the game
    collision = 1'b1;
    tick();
    collision = 1'b0;
    halt_in   = 1'b0;
    check_eq("coll_state", 32'(state), 0);
    check_eq("coll_over", 32'(game_over), 1);
    check_eq("coll_halt", 32'(game_halt), 1);

    // Cactus type latching
    random        = 5'b10100;
    cactus_select = 3'b000;
    tick();
    cactus_select = 3'b101;
    tick();
    check_eq("cac_rise", 32'(cactus_type), 32'b101);
    random = 5'b01000;
    tick();
    check_eq("cac_hold", 32'(cactus_type), 32'b101);
    cactus_select = 3'b111;
    tick();
    check_eq("cac_slot1", 32'(cactus_type), 32'b111);
    cactus_select = 3'b000;
    random        = 5'b00000;
    tick();
    check_eq("cac_fall", 32'(cactus_type), 32'b111);
    cactus_select = 3'b011;
    tick();
    check_eq("cac_multi", 32'(cactus_type), 32'b100);
    cactus_select = 3'b000;

    // Back into RUN, then asynchronous reset mid-cycle
    start_game();
    @(posedge clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check_eq("arst_state", 32'(state), 0);
    check_eq("arst_over", 32'(game_over), 1);
    check_eq("arst_cactus", 32'(cactus_type), 0);
    check_eq("arst_grst", 32'(game_rst), 0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    check_eq("arst_post_rst", 32'(game_rst), 0);
    check_eq("arst_post_st", 32'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
